// File: rtl/bitty_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, branch
// instruction format code and the default watchdog limit.
package bitty_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_MEM  = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_UPDATE    = 3'd5;

    // Instructions whose two low bits carry this code are branches.
    localparam logic [1:0] FMT_BRANCH = 2'b10;

    localparam int TIMEOUT_DEF = 32;

    function automatic logic is_branch(input logic [15:0] i);
        return i[1:0] == FMT_BRANCH;
    endfunction

endpackage

// File: rtl/fetch_wdog.sv
// Wait-state watchdog for fetch_seq. Loaded on clear, counts down one per
// enabled cycle; expire fires in the TIMEOUT-th consecutive enabled cycle.
module fetch_wdog #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic cnt_en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Down-counter: reload on clear, decrement while waiting, hold at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (cnt_en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = cnt_en && (cnt == '0);

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch/issue sequencer. Fetches one instruction at pc, hands it
// to the control unit with a one-cycle run pulse, waits for done, then
// advances pc (sequential or taken branch) and counts retired instructions.
// Optional wait-state watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// state       | meaning
// ------------|----------------------------------------------------------
// IDLE        | stopped; waits for start
// FETCH       | one-cycle read strobe at pc
// WAIT_MEM    | waits for mem_valid, captures instruction
// ISSUE       | one-cycle run pulse to the control unit
// WAIT_DONE   | waits for done, samples br_taken
// UPDATE      | advances pc and inst_cnt, stops if halt pending
module fetch_seq
    import bitty_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              halt,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [15:0]       mem_data,
    output logic [15:0]       inst,
    output logic              run,
    input  logic              done,
    input  logic              br_taken,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic [15:0]       inst_cnt,
    output logic              err
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       halt_pending;
    logic       br_q;
    logic       wd_expire;

`ifdef FETCH_TIMEOUT_EN
    logic wd_clear;
    logic wd_cnt_en;

    // Clear in the cycle before entering a wait state so the count starts
    // fresh on entry; count only while the awaited strobe is absent.
    assign wd_clear  = (state == S_FETCH) || (state == S_ISSUE);
    assign wd_cnt_en = ((state == S_WAIT_MEM)  && !mem_valid) ||
                       ((state == S_WAIT_DONE) && !done);

    fetch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .cnt_en (wd_cnt_en),
        .expire (wd_expire)
    );

    // Sticky error, cleared only by a new start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            err <= 1'b0;
        end else if (wd_expire) begin
            err <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    assign mem_rd   = (state == S_FETCH);
    assign mem_addr = pc;
    assign run      = (state == S_ISSUE);
    assign busy     = (state != S_IDLE);

    // Next-state decode; a watchdog expiry abandons the instruction.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_FETCH;
            S_FETCH:     state_nxt = S_WAIT_MEM;
            S_WAIT_MEM: begin
                if (mem_valid)      state_nxt = S_ISSUE;
                else if (wd_expire) state_nxt = S_IDLE;
            end
            S_ISSUE:     state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (done)           state_nxt = S_UPDATE;
                else if (wd_expire) state_nxt = S_IDLE;
            end
            S_UPDATE:    state_nxt = halt_pending ? S_IDLE : S_FETCH;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // State register and datapath: pc, instruction latch, branch sample, count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            inst     <= '0;
            inst_cnt <= '0;
            br_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc       <= start_addr;
                        inst_cnt <= '0;
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_valid) inst <= mem_data;
                end
                S_WAIT_DONE: begin
                    if (done) br_q <= br_taken;
                end
                S_UPDATE: begin
                    if (is_branch(inst) && br_q) pc <= ADDR_W'(inst[12:5]);
                    else                         pc <= pc + 1'b1;
                    if (inst_cnt != 16'hFFFF) inst_cnt <= inst_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Halt request latch: armed while running, dropped whenever we go idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_pending <= 1'b0;
        end else if (state_nxt == S_IDLE) begin
            halt_pending <= 1'b0;
        end else if ((state != S_IDLE) && halt) begin
            halt_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq. Plays memory and control unit from one
// directed/randomised sequence and predicts pc and retired count from the
// instruction stream with plain arithmetic.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_addr = '0;
    logic        halt = 1'b0;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_data = '0;
    logic        done = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] inst;
    logic        run;
    logic [7:0]  pc;
    logic        busy;
    logic [15:0] inst_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] pc_m;
    int cnt_m;
    int run_cyc[$];

    fetch_seq #(.ADDR_W(8), .TIMEOUT(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .halt       (halt),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .inst       (inst),
        .run        (run),
        .done       (done),
        .br_taken   (br_taken),
        .pc         (pc),
        .busy       (busy),
        .inst_cnt   (inst_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] a, input logic with_halt);
        @(negedge clk);
        start = 1'b1; start_addr = a; halt = with_halt;
        @(negedge clk);
        start = 1'b0; halt = 1'b0; start_addr = 8'($urandom);
        pc_m = a; cnt_m = 0;
        chk("start_busy", busy, 1);
        chk("start_pc", pc, a);
        chk("start_cnt", inst_cnt, 0);
    endtask

    // One complete instruction: memory answers after lat_m wait cycles,
    // control unit after lat_d; noise toggles inputs that must be ignored.
    task automatic fetch_one(input logic [15:0] d, input int lat_m, input int lat_d,
                             input logic br, input logic hlt, input logic noise);
        int n = 0;
        int act = 0;
        while (mem_rd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_strobe", mem_rd, 1);
        chk("fetch_addr", mem_addr, pc_m);
        @(negedge clk);
        chk("rd_one_cycle", mem_rd, 0);
        for (int i = 0; i < lat_m; i++) begin
            if (noise) begin
                done = 1'($urandom); br_taken = 1'($urandom);
                start = 1'($urandom); start_addr = 8'($urandom);
            end
            @(negedge clk);
        end
        done = 1'b0; start = 1'b0; mem_valid = 1'b1; mem_data = d;
        @(negedge clk);
        mem_valid = 1'b0; mem_data = 16'($urandom);
        chk("run_pulse", run, 1);
        chk("inst_capture", inst, d);
        run_cyc.push_back(cyc);
        @(negedge clk);
        chk("run_one_cycle", run, 0);
        if (hlt) halt = 1'b1;
        for (int i = 0; i < lat_d; i++) begin
            if (noise) begin
                mem_valid = 1'($urandom); mem_data = 16'($urandom);
                start = 1'($urandom); start_addr = 8'($urandom);
            end
            @(negedge clk);
            halt = 1'b0;
        end
        mem_valid = 1'b0; start = 1'b0; done = 1'b1; br_taken = br;
        @(negedge clk);
        done = 1'b0; halt = 1'b0; br_taken = 1'($urandom);
        chk("inst_stable", inst, d);
        pc_m = (d[1:0] == 2'b10 && br) ? d[12:5] : pc_m + 8'd1;
        if (cnt_m < 65535) cnt_m++;
        @(negedge clk);
        chk("pc_update", pc, pc_m);
        chk("inst_cnt", inst_cnt, cnt_m);
        if (hlt) begin
            chk("halt_idle", busy, 0);
            repeat (6) begin
                if (mem_rd || busy) act++;
                @(negedge clk);
            end
            chk("halt_quiet", act, 0);
        end
    endtask

    initial begin
        logic [7:0]  a;
        logic [15:0] d;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_run", run, 0);
        chk("rst_pc", pc, 0);
        chk("rst_inst", inst, 0);
        chk("rst_cnt", inst_cnt, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_mem_rd", mem_rd, 0);

        // Halt while idle must not stick.
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;

        // Three sequential instructions from 0x10, zero-wait everything.
        do_start(8'h10, 1'b0);
        run_cyc.delete();
        fetch_one(16'h0004, 0, 0, 1'b1, 1'b0, 1'b0);
        fetch_one(16'h1231, 0, 0, 1'b0, 1'b0, 1'b0);
        fetch_one(16'h00A3, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("run_spacing_a", run_cyc[1] - run_cyc[0], 5);
        chk("run_spacing_b", run_cyc[2] - run_cyc[1], 5);
        chk("seq_cnt", inst_cnt, 3);
        chk("seq_pc", pc, 8'h13);

        // Branch taken / not taken; halt together with start is ignored.
        do_start(8'h20, 1'b1);
        fetch_one(16'h0142, 1, 1, 1'b1, 1'b0, 1'b1);
        chk("branch_taken_pc", pc, 8'h0A);
        fetch_one(16'h0142, 0, 2, 1'b0, 1'b0, 1'b1);
        chk("branch_not_taken_pc", pc, 8'h0B);
        fetch_one(16'h5555, 0, 0, 1'b0, 1'b1, 1'b0);

        // Address wrap.
        do_start(8'hFF, 1'b0);
        fetch_one(16'h0000, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc", pc, 8'h00);
        fetch_one(16'hFFFF, 0, 0, 1'b1, 1'b1, 1'b0);

        // Random program with random latencies and ignored-input noise.
        a = 8'($urandom);
        do_start(a, 1'b0);
        for (int k = 0; k < 60; k++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d[1:0] = 2'b10;
            fetch_one(d, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), k == 59, 1'b1);
        end

        // Reset mid-instruction while waiting for done.
        do_start(8'h40, 1'b0);
        @(negedge clk);
        mem_valid = 1'b1; mem_data = 16'h1234;
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_run", run, 0);
        chk("mid_rst_mem_rd", mem_rd, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_inst", inst, 0);
        chk("mid_rst_cnt", inst_cnt, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        reset = 1'b1;
        mem_valid = 1'b1; done = 1'b1;
        repeat (5) @(negedge clk);
        mem_valid = 1'b0; done = 1'b0;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_mem_rd", mem_rd, 0);
        chk("post_rst_run", run, 0);

        // Memory never answers.
        do_start(8'h50, 1'b0);
        @(negedge clk);
        repeat (31) @(negedge clk);
        chk("wait_mem_held", busy, 1);
        chk("wait_mem_err", err, 0);
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        chk("wdog_err", err, 1);
        chk("wdog_idle", busy, 0);
        chk("wdog_pc", pc, 8'h50);
        chk("wdog_cnt", inst_cnt, 0);
        do_start(8'h60, 1'b0);
        chk("wdog_err_cleared", err, 0);
`else
        chk("no_wdog_busy", busy, 1);
        chk("no_wdog_err", err, 0);
        repeat (20) @(negedge clk);
        chk("no_wdog_still_busy", busy, 1);
`endif
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
